// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit processor controller: opcodes,
// instruction field positions and controller state encoding.
package proc_pkg;

   // Opcodes held in instruction bits [15:12]
   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_MOV  = 4'h6;
   localparam logic [3:0] OP_LDI  = 4'h7;
   localparam logic [3:0] OP_SHL  = 4'h8;
   localparam logic [3:0] OP_SHR  = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   // Instruction field bit positions (imm8 overlaps rs1/rs2, LDI only)
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int RD_HI  = 11;
   localparam int RD_LO  = 9;
   localparam int RS1_HI = 8;
   localparam int RS1_LO = 6;
   localparam int RS2_HI = 5;
   localparam int RS2_LO = 3;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_WB     = 3'd4,
      ST_HALTED = 3'd5
   } state_e;

   // Opcodes 0x0..0x9 and 0xF are defined; 0xA..0xE are not
   function automatic logic is_legal(input logic [3:0] op);
      return (op <= OP_SHR) || (op == OP_HALT);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, carry and zero for one instruction.
// Opcodes that do not define a carry pass carry_in through unchanged.
module alu_core
   import proc_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [7:0]        imm8,
   input  logic              carry_in,
   output logic [DATA_W-1:0] result,
   output logic              carry_out,
   output logic              zero
);

   logic [DATA_W:0] sum;

   // Operation select; the DATA_W+1-bit sum carries ADD carry and SUB borrow
   always_comb begin
      sum       = '0;
      result    = '0;
      carry_out = carry_in;
      case (op)
         OP_ADD: begin
            sum       = {1'b0, a} + {1'b0, b};
            result    = sum[DATA_W-1:0];
            carry_out = sum[DATA_W];
         end
         OP_SUB: begin
            sum       = {1'b0, a} - {1'b0, b};
            result    = sum[DATA_W-1:0];
            carry_out = sum[DATA_W];
         end
         OP_AND: begin result = a & b; carry_out = 1'b0; end
         OP_OR:  begin result = a | b; carry_out = 1'b0; end
         OP_XOR: begin result = a ^ b; carry_out = 1'b0; end
         OP_MOV: result = a;
         OP_LDI: result = DATA_W'(imm8);
         OP_SHL: begin result = {a[DATA_W-2:0], 1'b0}; carry_out = a[DATA_W-1]; end
         OP_SHR: begin result = {1'b0, a[DATA_W-1:1]}; carry_out = a[0]; end
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/decode_exec_ctrl.sv
// Fetch/decode/execute/writeback controller for the 8-bit processor.
// Instruction handshake: a word transfers on a rising edge where both
// instr_valid and instr_ready are high; instr_ready is only high in FETCH.
module decode_exec_ctrl
   import proc_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 3,
   parameter int INSTR_W = 16,
   parameter int PC_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic [PC_W-1:0]    pc,
   output logic [ADDR_W-1:0]  read_reg1,
   output logic [ADDR_W-1:0]  read_reg2,
   input  logic [DATA_W-1:0]  read_data1,
   input  logic [DATA_W-1:0]  read_data2,
   output logic [ADDR_W-1:0]  write_reg,
   output logic [DATA_W-1:0]  write_data,
   output logic               reg_write,
   output logic               zero_flag,
   output logic               carry_flag,
   output logic               illegal_op,
   output logic               halted,
   output logic               busy,
   output logic [2:0]         dbg_state
);

   state_e              state_q, state_d;
   logic [INSTR_W-1:0]  ir_q, ir_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [ADDR_W-1:0]   rr1_q, rr1_d, rr2_q, rr2_d;
   logic [ADDR_W-1:0]   wr_reg_q, wr_reg_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                reg_write_q, reg_write_d;
   logic                zero_q, zero_d, carry_q, carry_d;
   logic                illegal_q, illegal_d;
   logic                ready_q, ready_d;
   logic                halted_q, halted_d;
   logic                busy_q, busy_d;

   logic [3:0]          op;
   logic [DATA_W-1:0]   alu_result;
   logic                alu_carry, alu_zero;

   assign op = ir_q[OPC_HI:OPC_LO];

   alu_core #(.DATA_W(DATA_W)) u_alu (
      .op        (op),
      .a         (read_data1),
      .b         (read_data2),
      .imm8      (ir_q[IMM_HI:IMM_LO]),
      .carry_in  (carry_q),
      .result    (alu_result),
      .carry_out (alu_carry),
      .zero      (alu_zero)
   );

   // Next-state and next-value logic; status outputs are decoded from state_d
   // so they are registered alongside the state
   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      pc_d        = pc_q;
      rr1_d       = rr1_q;
      rr2_d       = rr2_q;
      wr_reg_d    = wr_reg_q;
      wr_data_d   = wr_data_q;
      reg_write_d = 1'b0;
      zero_d      = zero_q;
      carry_d     = carry_q;
      illegal_d   = illegal_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_FETCH;
         ST_FETCH: begin
            if (instr_valid && ready_q) begin
               ir_d    = instr;
               pc_d    = pc_q + 1'b1;
               // read addresses are ready during DECODE and held through EXEC
               rr1_d   = instr[RS1_HI:RS1_LO];
               rr2_d   = instr[RS2_HI:RS2_LO];
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC: begin
            if (op == OP_HALT) begin
               state_d = ST_HALTED;
            end else if (op == OP_NOP || !is_legal(op)) begin
               illegal_d = illegal_q | ~is_legal(op);
               state_d   = ST_FETCH;
            end else begin
               wr_reg_d    = ir_q[RD_HI:RD_LO];
               wr_data_d   = alu_result;
               carry_d     = alu_carry;
               zero_d      = alu_zero;
               reg_write_d = 1'b1;
               state_d     = ST_WB;
            end
         end
         ST_WB:     state_d = ST_FETCH;
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase
      ready_d  = (state_d == ST_FETCH);
      halted_d = (state_d == ST_HALTED);
      busy_d   = (state_d != ST_IDLE) && (state_d != ST_HALTED);
   end

   // Controller registers; asynchronous reset discards any in-flight write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ir_q        <= '0;
         pc_q        <= '0;
         rr1_q       <= '0;
         rr2_q       <= '0;
         wr_reg_q    <= '0;
         wr_data_q   <= '0;
         reg_write_q <= 1'b0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         illegal_q   <= 1'b0;
         ready_q     <= 1'b0;
         halted_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         pc_q        <= pc_d;
         rr1_q       <= rr1_d;
         rr2_q       <= rr2_d;
         wr_reg_q    <= wr_reg_d;
         wr_data_q   <= wr_data_d;
         reg_write_q <= reg_write_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         illegal_q   <= illegal_d;
         ready_q     <= ready_d;
         halted_q    <= halted_d;
         busy_q      <= busy_d;
      end
   end

   assign instr_ready = ready_q;
   assign pc          = pc_q;
   assign read_reg1   = rr1_q;
   assign read_reg2   = rr2_q;
   assign write_reg   = wr_reg_q;
   assign write_data  = wr_data_q;
   assign reg_write   = reg_write_q;
   assign zero_flag   = zero_q;
   assign carry_flag  = carry_q;
   assign illegal_op  = illegal_q;
   assign halted      = halted_q;
   assign busy        = busy_q;
   assign dbg_state   = state_q;

endmodule
